// File: rtl/trig_pkg.sv
// Shared sizing, per-channel state encoding and coax line levels for the
// detector-side coax trigger transmitter.
package trig_pkg;
  localparam int NCHAN = 16;
  localparam int CNTW  = 32;
  localparam int TW    = 8;
  localparam int SELW  = $clog2(NCHAN);

  // The trigger board inverts its inputs: an idle line sits high.
  localparam logic COAX_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } chan_state_t;
endpackage

// File: rtl/coax_trig_tx_if.sv
// Slow-control snapshot port: 4-phase req/ack with a channel select and the
// captured counter value.
interface coax_trig_tx_if;
  import trig_pkg::*;

  logic            snap_req;
  logic [SELW-1:0] count_sel;
  logic            snap_ack;
  logic [CNTW-1:0] count_out;

  modport master (output snap_req, count_sel, input snap_ack, count_out);
  modport slave  (input snap_req, count_sel, output snap_ack, count_out);
endinterface

// File: rtl/coax_tx_chan.sv
// One coax channel: IDLE/PULSE/HOLD sequencer with a shared width/holdoff
// down-counter and a saturating fired-pulse counter.
module coax_tx_chan
  import trig_pkg::*;
(
  input  logic            clk_adc,
  input  logic            reset,
  input  logic            fire_req,
  input  logic            clear,
  input  logic [TW-1:0]   pulse_width,
  input  logic [TW-1:0]   holdoff,
  output logic            coax,
  output logic            busy,
  output logic            dropped,
  output logic [CNTW-1:0] cnt
);
  chan_state_t     state_reg, state_next;
  logic [TW-1:0]   tmr_reg, tmr_next;
  logic [TW-1:0]   hlat_reg, hlat_next;
  logic [CNTW-1:0] cnt_reg;
  logic            coax_reg;
  logic            busy_reg;
  logic            fire;

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    hlat_next  = hlat_reg;
    fire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fire_req) begin
          // Width and holdoff are frozen here so a pulse in flight ignores later edits.
          state_next = PULSE;
          tmr_next   = (pulse_width == '0) ? TW'(1) : pulse_width;
          hlat_next  = holdoff;
          fire       = 1'b1;
        end
      end
      PULSE: begin
        if (tmr_reg <= TW'(1)) begin
          if (hlat_reg != '0) begin
            state_next = HOLD;
            tmr_next   = hlat_reg;
          end else begin
            state_next = IDLE;
            tmr_next   = '0;
          end
        end else begin
          tmr_next = tmr_reg - TW'(1);
        end
      end
      HOLD: begin
        if (tmr_reg <= TW'(1)) begin
          state_next = IDLE;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr_reg - TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tmr_next   = '0;
      end
    endcase
  end

  assign dropped = fire_req && (state_reg != IDLE);

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state_reg <= IDLE;
      tmr_reg   <= '0;
      hlat_reg  <= '0;
      cnt_reg   <= '0;
      coax_reg  <= COAX_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      hlat_reg  <= hlat_next;
      coax_reg  <= (state_next == PULSE) ? ~COAX_IDLE : COAX_IDLE;
      busy_reg  <= (state_next != IDLE);
      if (clear)
        cnt_reg <= '0;
      else if (fire && (cnt_reg != '1))
        cnt_reg <= cnt_reg + CNTW'(1);
    end
  end

  assign coax = coax_reg;
  assign busy = busy_reg;
  assign cnt  = cnt_reg;
endmodule

// File: rtl/coax_trig_tx.sv
// Coax trigger transmitter top: edge detect, NCHAN channel instances,
// saturating drop tally and the 4-phase counter snapshot port.
module coax_trig_tx
  import trig_pkg::*;
(
  input  logic             clk_adc,
  input  logic             reset,
  input  logic [NCHAN-1:0] hit_in,
  input  logic [NCHAN-1:0] chan_enable,
  input  logic             test_fire,
  input  logic [TW-1:0]    pulse_width,
  input  logic [TW-1:0]    holdoff,
  output logic [NCHAN-1:0] coax_out,
  output logic [NCHAN-1:0] busy,
  input  logic             clear_counts,
  coax_trig_tx_if.slave    snap,
  output logic [CNTW-1:0]  drop_count
);
  localparam int POPW = $clog2(NCHAN + 1);

  logic [NCHAN-1:0] hit_d_reg;
  logic [NCHAN-1:0] fire_req;
  logic [NCHAN-1:0] dropped;
  logic [CNTW-1:0]  cnt_arr [NCHAN];
  logic [POPW-1:0]  drop_pop;
  logic [CNTW:0]    drop_sum;
  logic [CNTW-1:0]  drop_count_reg;
  logic             snap_ack_reg;
  logic [CNTW-1:0]  count_out_reg;

  // A level held high fires once; test_fire hits every enabled channel.
  assign fire_req = chan_enable & ((hit_in & ~hit_d_reg) | {NCHAN{test_fire}});

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      coax_tx_chan u_chan (
        .clk_adc     (clk_adc),
        .reset       (reset),
        .fire_req    (fire_req[gi]),
        .clear       (clear_counts),
        .pulse_width (pulse_width),
        .holdoff     (holdoff),
        .coax        (coax_out[gi]),
        .busy        (busy[gi]),
        .dropped     (dropped[gi]),
        .cnt         (cnt_arr[gi])
      );
    end
  endgenerate

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NCHAN; i++)
      drop_pop = drop_pop + POPW'(dropped[i]);
  end

  assign drop_sum = {1'b0, drop_count_reg} + {{(CNTW + 1 - POPW){1'b0}}, drop_pop};

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      hit_d_reg      <= '0;
      drop_count_reg <= '0;
    end else begin
      hit_d_reg <= hit_in;
      if (clear_counts)
        drop_count_reg <= '0;
      else if (drop_sum[CNTW])
        drop_count_reg <= '1;
      else
        drop_count_reg <= drop_sum[CNTW-1:0];
    end
  end

  // Capture only on a fresh request; select changes while acked are ignored.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      snap_ack_reg  <= 1'b0;
      count_out_reg <= '0;
    end else if (snap.snap_req && !snap_ack_reg) begin
      snap_ack_reg  <= 1'b1;
      count_out_reg <= cnt_arr[snap.count_sel];
    end else if (!snap.snap_req && snap_ack_reg) begin
      snap_ack_reg <= 1'b0;
    end
  end

  assign snap.snap_ack  = snap_ack_reg;
  assign snap.count_out = count_out_reg;
  assign drop_count     = drop_count_reg;
endmodule

// File: tb/tb_coax_trig_tx.sv
// Scenario bench for coax_trig_tx: per-cycle expected line/busy values are
// queued as stimulus is driven and popped after each clock edge.
module tb_coax_trig_tx;
  logic        clk_adc = 1'b0;
  logic        reset;
  logic [15:0] hit_in;
  logic [15:0] chan_enable;
  logic        test_fire;
  logic [7:0]  pulse_width;
  logic [7:0]  holdoff;
  logic [15:0] coax_out;
  logic [15:0] busy;
  logic        clear_counts;
  logic [31:0] drop_count;

  coax_trig_tx_if snap ();

  coax_trig_tx dut (
    .clk_adc      (clk_adc),
    .reset        (reset),
    .hit_in       (hit_in),
    .chan_enable  (chan_enable),
    .test_fire    (test_fire),
    .pulse_width  (pulse_width),
    .holdoff      (holdoff),
    .coax_out     (coax_out),
    .busy         (busy),
    .clear_counts (clear_counts),
    .snap         (snap.slave),
    .drop_count   (drop_count)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct packed {
    logic [15:0] coax;
    logic [15:0] busy;
    logic        chk_busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [15:0] low_mask, input logic [15:0] bz, input logic cb);
    exp_t r;
    r.coax     = ~low_mask;
    r.busy     = bz;
    r.chk_busy = cb;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hit_in = '0; test_fire = 1'b0; clear_counts = 1'b0;
    snap.snap_req = 1'b0; snap.count_sel = 4'd0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic snap_read(input logic [3:0] sel, output logic [31:0] val,
                           output logic ack_up, output logic ack_down);
    snap.count_sel = sel; snap.snap_req = 1'b1;
    step();
    ack_up = snap.snap_ack; val = snap.count_out;
    snap.snap_req = 1'b0;
    step();
    ack_down = snap.snap_ack;
  endtask

  task automatic test_reset();
    hit_in = 16'hFFFF; chan_enable = 16'hFFFF; pulse_width = 8'd5; holdoff = 8'd0;
    reset = 1'b1; test_fire = 1'b0; clear_counts = 1'b0;
    snap.snap_req = 1'b0; snap.count_sel = 4'd0;
    step(); step();
    checks++; if (coax_out !== 16'hFFFF) begin errors++; $display("FAIL reset_coax got %h exp ffff", coax_out); end
    checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy); end
    checks++; if (snap.snap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", snap.snap_ack); end
    checks++; if (snap.count_out !== 32'd0) begin errors++; $display("FAIL reset_count_out got %0d exp 0", snap.count_out); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    $display("test_reset done");
  endtask

  task automatic test_single_pulse();
    logic [31:0] v; logic au, ad;
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd5; holdoff = 8'd0;
    for (int c = 0; c <= 20; c++) begin
      hit_in = (c >= 10) ? 16'h0008 : 16'h0000;
      exp_q.push_back(mk((c >= 10 && c <= 14) ? 16'h0008 : 16'h0000, 16'h0, 1'b0));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL single_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
    end
    snap_read(4'd3, v, au, ad);
    checks++; if (au !== 1'b1) begin errors++; $display("FAIL single_ack_up got %b exp 1", au); end
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL single_cnt3 got %0d exp 1", v); end
    checks++; if (ad !== 1'b0) begin errors++; $display("FAIL single_ack_down got %b exp 0", ad); end
    $display("test_single_pulse cnt3=%0d", v);
  endtask

  task automatic test_holdoff();
    logic [31:0] v; logic au, ad;
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd4; holdoff = 8'd10;
    for (int c = 0; c <= 30; c++) begin
      hit_in = (c == 0 || c == 6 || c == 20) ? 16'h0001 : 16'h0000;
      exp_q.push_back(mk((c <= 3 || (c >= 20 && c <= 23)) ? 16'h0001 : 16'h0000,
                         (c <= 13 || c >= 20) ? 16'h0001 : 16'h0000, 1'b1));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL holdoff_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
      checks++; if (busy !== e.busy) begin errors++; $display("FAIL holdoff_busy c=%0d got %h exp %h", c, busy, e.busy); end
    end
    checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL holdoff_drop got %0d exp 1", drop_count); end
    snap_read(4'd0, v, au, ad);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL holdoff_cnt0 got %0d exp 2", v); end
    $display("test_holdoff drop=%0d cnt0=%0d", drop_count, v);
  endtask

  task automatic test_test_fire();
    do_reset();
    chan_enable = 16'h00FF; pulse_width = 8'd0; holdoff = 8'd0; hit_in = '0;
    for (int c = 0; c <= 5; c++) begin
      test_fire = (c == 2);
      exp_q.push_back(mk((c == 2) ? 16'h00FF : 16'h0000, (c == 2) ? 16'h00FF : 16'h0000, 1'b1));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL testfire_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
      checks++; if (busy !== e.busy) begin errors++; $display("FAIL testfire_busy c=%0d got %h exp %h", c, busy, e.busy); end
    end
    test_fire = 1'b0;
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL testfire_drop got %0d exp 0", drop_count); end
    $display("test_test_fire done");
  endtask

  task automatic test_held_level();
    logic [31:0] v; logic au, ad;
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd3; holdoff = 8'd0;
    for (int c = 0; c <= 105; c++) begin
      hit_in = (c >= 1 && c <= 100) ? 16'h0080 : 16'h0000;
      exp_q.push_back(mk((c >= 1 && c <= 3) ? 16'h0080 : 16'h0000, 16'h0, 1'b0));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL held_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
    end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL held_drop got %0d exp 0", drop_count); end
    snap_read(4'd7, v, au, ad);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL held_cnt7 got %0d exp 1", v); end
    $display("test_held_level cnt7=%0d", v);
  endtask

  task automatic test_width_change();
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd8; holdoff = 8'd0;
    for (int c = 0; c <= 18; c++) begin
      hit_in = (c == 1 || c == 12) ? 16'h0004 : 16'h0000;
      if (c >= 2) pulse_width = 8'd2;
      exp_q.push_back(mk(((c >= 1 && c <= 8) || c == 12 || c == 13) ? 16'h0004 : 16'h0000, 16'h0, 1'b0));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL width_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
    end
    $display("test_width_change done");
  endtask

  task automatic test_clear_coincide();
    logic [31:0] v; logic au, ad;
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd3; holdoff = 8'd0;
    for (int c = 0; c <= 15; c++) begin
      hit_in = (c == 1 || c == 3 || c == 10) ? 16'h0002 : 16'h0000;
      clear_counts = (c == 10);
      exp_q.push_back(mk(((c >= 1 && c <= 3) || (c >= 10 && c <= 12)) ? 16'h0002 : 16'h0000, 16'h0, 1'b0));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL clear_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
      if (c == 9) begin
        checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL clear_drop_before got %0d exp 1", drop_count); end
      end
    end
    clear_counts = 1'b0;
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL clear_drop_after got %0d exp 0", drop_count); end
    snap_read(4'd1, v, au, ad);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL clear_cnt1 got %0d exp 0", v); end
    $display("test_clear_coincide cnt1=%0d", v);
  endtask

  task automatic test_snapshot();
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd1; holdoff = 8'd0;
    for (int c = 0; c <= 7; c++) begin
      hit_in = (c == 1 || c == 4) ? 16'h0010 : 16'h0000;
      exp_q.push_back(mk((c == 1 || c == 4) ? 16'h0010 : 16'h0000, 16'h0, 1'b0));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL snap_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
    end
    snap.count_sel = 4'd4; snap.snap_req = 1'b1;
    step();
    checks++; if (snap.snap_ack !== 1'b1) begin errors++; $display("FAIL snap_ack_rise got %b exp 1", snap.snap_ack); end
    checks++; if (snap.count_out !== 32'd2) begin errors++; $display("FAIL snap_cnt4 got %0d exp 2", snap.count_out); end
    snap.count_sel = 4'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (snap.snap_ack !== 1'b1) begin errors++; $display("FAIL snap_ack_hold k=%0d got %b exp 1", k, snap.snap_ack); end
      checks++; if (snap.count_out !== 32'd2) begin errors++; $display("FAIL snap_val_hold k=%0d got %0d exp 2", k, snap.count_out); end
    end
    snap.snap_req = 1'b0;
    step();
    checks++; if (snap.snap_ack !== 1'b0) begin errors++; $display("FAIL snap_ack_fall got %b exp 0", snap.snap_ack); end
    checks++; if (snap.count_out !== 32'd2) begin errors++; $display("FAIL snap_val_keep got %0d exp 2", snap.count_out); end
    snap.snap_req = 1'b1;
    step();
    checks++; if (snap.count_out !== 32'd0) begin errors++; $display("FAIL snap_cnt5 got %0d exp 0", snap.count_out); end
    snap.snap_req = 1'b0;
    step();
    $display("test_snapshot done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] v; logic au, ad;
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd2; holdoff = 8'd0;
    for (int c = 0; c <= 9; c++) begin
      hit_in = (c == 1 || c == 4) ? 16'h0200 : 16'h0000;
      exp_q.push_back(mk((c == 1 || c == 2 || c == 4 || c == 5) ? 16'h0200 : 16'h0000, 16'h0, 1'b0));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL b2b_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
    end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop_count); end
    snap_read(4'd9, v, au, ad);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL b2b_cnt9 got %0d exp 2", v); end
    $display("test_back_to_back cnt9=%0d", v);
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    chan_enable = 16'hFFFF; pulse_width = 8'd10; holdoff = 8'd0;
    for (int c = 0; c <= 8; c++) begin
      hit_in = (c == 1) ? 16'h0040 : 16'h0000;
      reset = (c == 4 || c == 5);
      exp_q.push_back(mk((c >= 1 && c <= 3) ? 16'h0040 : 16'h0000,
                         (c >= 1 && c <= 3) ? 16'h0040 : 16'h0000, 1'b1));
      step();
      e = exp_q.pop_front();
      checks++; if (coax_out !== e.coax) begin errors++; $display("FAIL rstmid_coax c=%0d got %h exp %h", c, coax_out, e.coax); end
      checks++; if (busy !== e.busy) begin errors++; $display("FAIL rstmid_busy c=%0d got %h exp %h", c, busy, e.busy); end
    end
    reset = 1'b0;
    $display("test_reset_mid_pulse done");
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_holdoff();
    test_test_fire();
    test_held_level();
    test_width_change();
    test_clear_coincide();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/coax_trig_tx.md
Name: coax_trig_tx

Overview:
Transmit end of the inter-board coax trigger link, on the detector/readout board. Turns per-channel discriminator levels into fixed-width, active-low coax pulses with a per-channel holdoff. The trigger board inverts its inputs, so idle = 1 and a firing channel = 0. Keeps per-channel fired-pulse counters, read out one at a time through a 4-phase snapshot handshake from the slow-control side.

Parameters:
NCHAN, 16, number of coax channels
CNTW, 32, fired-pulse counter width
TW, 8, width of pulse_width/holdoff fields

Ports:
clk_adc  in  1  sole clock
reset  in  1  synchronous, active-high
hit_in  in  NCHAN  discriminator levels, already synchronous to clk_adc
chan_enable  in  NCHAN  1 = channel may fire
test_fire  in  1  one-cycle strobe; fires every enabled, idle channel
pulse_width  in  TW  output low time in clk_adc ticks; 0 treated as 1
holdoff  in  TW  ticks after pulse end before the channel re-arms
coax_out  out  NCHAN  to coax drivers, active low, idle 1
busy  out  NCHAN  1 while channel is in PULSE or HOLD
clear_counts  in  1  zeroes all counters
count_sel  in  4  channel to snapshot
snap_req  in  1  4-phase request (level)
snap_ack  out  1  4-phase acknowledge
count_out  out  CNTW  snapshot value; valid while snap_ack=1
drop_count  out  CNTW  total rejected edges, saturating

Behaviour:
- Reset, synchronous: coax_out=all 1; busy=0; snap_ack=0; count_out=0; drop_count=0; all counters 0; all channels IDLE; hit_d=0. Reset mid-pulse releases the line to 1 on the next edge.
- Edge detect: hit_d <= hit_in. fire_req[i] = chan_enable[i] & ((hit_in[i] & ~hit_d[i]) | test_fire). A held-high level fires once only.
- Per-channel FSM:
  - IDLE -> PULSE on fire_req. Latch wlat = max(pulse_width,1) and hlat = holdoff at this point. Later input changes do not affect a pulse in progress.
  - PULSE: coax_out[i]=0 for exactly wlat cycles. Then go to HOLD if hlat>0, else to IDLE.
  - HOLD: hlat cycles, then IDLE.
- Latency: edge sampled at cycle n -> coax_out low in cycles n+1 .. n+wlat (registered output). busy mirrors state with the same registered timing.
- Re-arm: with holdoff=0, a new edge in the first IDLE cycle after the pulse fires again, giving one high cycle between pulses.
- Drops: a fire_req arriving in PULSE or HOLD is ignored. It adds 1 to drop_count, with at most +NCHAN per cycle (popcount of dropped requests). drop_count saturates at all-ones.
- Disabled channels: no fire, no drop. Clearing chan_enable mid-pulse does not truncate the pulse.
- Counters: cnt[i] +1 on each IDLE->PULSE transition, saturating at 2^CNTW-1. clear_counts zeroes cnt[] and drop_count; if it coincides with a fire or drop, clear wins and the event is not counted.
- Snapshot, 4-phase:
  - snap_req=1 & snap_ack=0: capture cnt[count_sel] into count_out; snap_ack=1 next cycle.
  - Hold count_out and snap_ack while snap_req=1.
  - snap_req=0 & snap_ack=1: snap_ack=0 next cycle; count_out keeps its value.
  - A new capture needs ack to have returned to 0. count_sel changes during ack=1 are ignored.
- Widths: down-counters are TW bits and never underflow. All arithmetic is unsigned.

Decomposition:
- Shared package trig_pkg:
  - NCHAN, CNTW, TW
  - enum chan_state_t {IDLE, PULSE, HOLD}
  - the idle coax level constant (1)
- One sub-module, coax_tx_chan: a single channel's FSM, width/holdoff down-counter and saturating counter. It is generated NCHAN times.
- The top level holds the edge detect, drop popcount, snapshot handshake and count mux.

Test Plan:
- Reset, then pulse_width=5, holdoff=0: hit_in[3] rises at cycle 10 -> coax_out[3]=0 in cycles 11-15 only, all other lines 1. Snapshot with count_sel=3 -> count_out=1.
- pulse_width=4, holdoff=10: edges on ch0 at cycles 0, 6 and 20 -> pulses start at cycles 1 and 21 only; drop_count=1; cnt[0]=2.
- pulse_width=0, chan_enable=16'h00FF, test_fire strobe -> lines 0-7 low for exactly 1 cycle, lines 8-15 stay 1, busy=16'h00FF for that cycle.
- hit_in[7] held high for 100 cycles with pulse_width=3 -> exactly one pulse; cnt[7]=1, drop_count=0.
- pulse_width=8, ch2 fires, then pulse_width changes to 2 one cycle later -> the first pulse is still 8 cycles long; the next pulse is 2 cycles long.
- clear_counts asserted in the same cycle as a ch1 fire -> cnt[1]=0 afterwards, but coax_out[1] still pulses. Snapshot handshake: snap_ack rises 1 cycle after snap_req and falls 1 cycle after snap_req drops. reset asserted mid-pulse -> all lines 1 on the next edge.
